// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-RAM arbiter: RAM status codes and the latched request payload.
package mem_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef struct packed {
        logic              isWrite;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] store;
    } ramreq_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-port unified RAM between instruction fetch and the data port.
// Data wins arbitration; persistent RAM errors are converted into a sticky fault flag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  ramstate_t         ramstate,
    input  logic [WORD_W-1:0] ramload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              fault
);

    localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] LAST_ERR = CNT_W'(MAX_RETRY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    ramreq_t          req;
    ramreq_t          reqNext;
    logic [CNT_W-1:0] retryCnt;
    logic [CNT_W-1:0] retryNext;
    logic             faultReg;
    logic             faultNext;
    logic             dReq;
    logic             ownerReq;

    assign dReq     = dREN | dWEN;
    assign ownerReq = (state == DGNT) ? dReq : iREN;

    // RAM address and store data only ever come from the latched request.
    assign ramaddr  = req.addr;
    assign ramstore = req.store;
    assign fault    = faultReg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            req      <= '0;
            retryCnt <= '0;
            faultReg <= 1'b0;
        end else begin
            state    <= stateNext;
            req      <= reqNext;
            retryCnt <= retryNext;
            faultReg <= faultNext;
        end
    end

    // Arbitration, completion, abort and retry accounting.
    always_comb begin
        stateNext = state;
        reqNext   = req;
        retryNext = retryCnt;
        faultNext = faultReg;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = '0;
        dload     = '0;

        unique case (state)
            IDLE: begin
                if (dReq) begin
                    reqNext.isWrite = dWEN;
                    reqNext.addr    = daddr;
                    reqNext.store   = dstore;
                    retryNext       = '0;
                    stateNext       = DGNT;
                end else if (iREN) begin
                    reqNext.addr = iaddr;
                    retryNext    = '0;
                    stateNext    = IGNT;
                end
            end

            DGNT, IGNT: begin
                ramREN = (state == IGNT) || !req.isWrite;
                ramWEN = (state == DGNT) && req.isWrite;

                if (ramstate == ACCESS) begin
                    if (state == DGNT) begin
                        dhit  = 1'b1;
                        dload = ramload;
                    end else begin
                        ihit  = 1'b1;
                        iload = ramload;
                    end
                    stateNext = IDLE;
                end else if (!ownerReq) begin
                    stateNext = IDLE;
                end else if (ramstate == ERROR) begin
                    // The last tolerated error abandons the transaction.
                    if (retryCnt == LAST_ERR) begin
                        retryNext = CNT_MAX;
                        faultNext = 1'b1;
                        stateNext = IDLE;
                    end else if (retryCnt < CNT_MAX) begin
                        retryNext = retryCnt + CNT_W'(1);
                    end
                end
            end

            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares the single-port unified RAM between the instruction-fetch port (`iREN`) and the data port (`dREN`/`dWEN`) driven by the datapath and control unit. Each granted request becomes one RAM transaction, and the arbiter returns `ihit`/`dhit` to the requester when the RAM reports `ACCESS`. Data requests have priority. A bounded retry counter converts a persistent RAM `ERROR` into a sticky fault flag.

## Interface
Parameters:
- `MAX_RETRY`, default 4: number of `ERROR` responses tolerated within one transaction before the transaction is abandoned and `fault` is set.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  1  instruction read request.
- `iaddr`  in  32  instruction word address.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request; `dREN` and `dWEN` are never both high.
- `daddr`  in  32  data address.
- `dstore`  in  32  data write value.
- `ramstate`  in  `ramstate_t`  RAM status: `FREE`, `BUSY`, `ACCESS` or `ERROR`.
- `ramload`  in  32  RAM read data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ihit`  out  1  one-cycle pulse: the instruction read has completed.
- `dhit`  out  1  one-cycle pulse: the data read or write has completed.
- `iload`  out  32  instruction data; valid while `ihit` is high.
- `dload`  out  32  data read value; valid while `dhit` is high.
- `fault`  out  1  sticky flag: a transaction was abandoned after `MAX_RETRY` errors.

## Operation
- State machine with states `IDLE`, `DGNT`, `IGNT`.
- In `IDLE`:
  - `dREN` or `dWEN` high: latch `daddr`, `dstore` and the operation; go to `DGNT`.
  - Otherwise, `iREN` high: latch `iaddr`; go to `IGNT`.
  - Otherwise stay in `IDLE`.
- While in a grant state:
  - The RAM outputs are driven only from the latched registers.
  - `DGNT` read: `ramREN`=1, `ramWEN`=0.
  - `DGNT` write: `ramWEN`=1, `ramREN`=0, `ramstore` = latched `dstore`.
  - `IGNT`: `ramREN`=1, `ramWEN`=0.
  - In `IDLE`, all RAM enables are 0 and `ramaddr`/`ramstore` hold their last values.
- Completion: `ramstate==ACCESS` in a grant state causes the following:
  - The matching hit is high combinationally in that same cycle.
  - `iload` or `dload` = `ramload`; both are 0 when the matching hit is low.
  - The next state is `IDLE`.
- `BUSY` or `FREE` in a grant state: hold the state; no hit.
- `ERROR` in a grant state:
  - Increment `retry_cnt`, which is `$clog2(MAX_RETRY+1)` bits wide and does not saturate past `MAX_RETRY`.
  - On the `MAX_RETRY`-th error: set `fault`, go to `IDLE`, no hit.
  - `retry_cnt` clears on every entry into a grant state.
- Abort: if the owning request drops while its grant state is active and `ramstate!=ACCESS`, the transaction is cancelled.
  - Data owner: `dREN|dWEN` low.
  - Instruction owner: `iREN` low.
  - Next state is `IDLE`, with no hit.
- Simultaneous requests in `IDLE`: data always wins. The instruction request stays pending and is granted after the data transaction ends.
- Once set, `fault` stays high until `nRST`; it does not block further grants.

## Timing
- Reset (`nRST` low, asynchronous) puts the block in this state:
  - State `IDLE`; latched address, latched store data and `retry_cnt` = 0.
  - `fault` = 0.
  - All outputs 0.
- Reset mid-transaction: outputs go to 0 immediately and no hit is issued.
- Arbitration latency: a request first seen in `IDLE` at edge N appears on the RAM port in the cycle after edge N.
- Minimum request-to-hit time is 1 cycle plus the RAM latency.
- Every completion or abort passes through one `IDLE` cycle. This lets the requester deassert its request after a hit without being re-granted.
- Back-to-back data then instruction: the instruction grant starts 2 cycles after the data hit cycle.
  - Hit cycle.
  - `IDLE` cycle.
  - `IGNT`.
- Exactly one of `ihit`/`dhit` can be high in any cycle. Each is high for exactly one cycle per completed transaction.
- The request inputs are sampled only in `IDLE` and in grant states (for abort). Address and data changes during a grant have no effect.

## Test plan
- Reset: assert `nRST`=0 mid-`DGNT` → `ramREN`/`ramWEN`/hits drop to 0 immediately; after release, state `IDLE` and `fault`=0.
- Instruction read: `iREN`=1, `iaddr`=0x40, RAM returns `ACCESS` after 2 `BUSY` cycles with `ramload`=0x2001FFFF → `ramaddr`=0x40 from cycle 1; `ihit`=1 and `iload`=0x2001FFFF in cycle 3 only.
- Contention: `iREN`=1 and `dWEN`=1 in the same `IDLE` cycle, `daddr`=0x80, `dstore`=0xDEADBEEF → write issued first with `ramstore`=0xDEADBEEF; `dhit` pulses; one `IDLE` cycle; then the instruction read is issued and `ihit` follows.
- Abort: in `DGNT` with `ramstate`=`BUSY`, drop `dREN` → `IDLE` next cycle; no `dhit`; `ramREN`=0.
- Retry and fault, with `MAX_RETRY`=4:
  - 3 `ERROR` cycles then `ACCESS` → `dhit` pulses and `fault` stays 0.
  - 4 consecutive `ERROR` cycles → `fault`=1, no hit, return to `IDLE`; `fault` persists across later successful transactions.
- Address hold: change `daddr` from 0x80 to 0xFC mid-`DGNT` → `ramaddr` stays 0x80 until completion.
